// File: rtl/ab_cbrt_mul_param.sv
// Sequential y = a * floor(cbrt(b)) unit with root-only and multiply-only modes.
// One serial shift-add multiplier is shared by the cube-root loop and the final product.
`timescale 1ns/1ps
module ab_cbrt_mul_param #(
   parameter int WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   input  logic [1:0]           mode_i,
   input  logic                 start_i,
   output logic [2*WIDTH-1:0]   y_bo,
   output logic                 busy_o,
   output logic                 done_o
);

   // state     | meaning
   // IDLE      | waiting for start_i
   // ROOT_PREP | double partial root, load multiplier with y and y+1
   // ROOT_MUL  | serial y*(y+1), WIDTH+1 cycles
   // ROOT_CMP  | trial subtract of (3y(y+1)+1) << s, advance iteration
   // MUL       | serial a*y or a*b, WIDTH cycles
   // DONE      | publish result, pulse done_o

   localparam int K  = (WIDTH + 2) / 3;
   localparam int MW = 2*WIDTH + 2;
   localparam int TW = 3*WIDTH + 2;
   localparam int IW = $clog2(K + 1);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ROOT_PREP, S_ROOT_MUL, S_ROOT_CMP, S_MUL, S_DONE
   } state_t;

   state_t            state_r, state_nxt;
   logic [WIDTH-1:0]  a_r, x_r, y_r;
   logic [1:0]        mode_r;
   logic [IW-1:0]     i_r;
   logic [CW-1:0]     cnt_r;
   logic [MW-1:0]     mcand_r, acc_r;
   logic [WIDTH:0]    mplier_r;

   logic [TW-1:0]     t_val;
   logic              root_ge;
   logic              last_iter;
   logic [WIDTH-1:0]  y_inc;
   int                shift_amt;

   always_comb begin
      shift_amt = 3 * (K - 1 - int'(i_r));
      t_val     = ((TW'(acc_r) << 1) + TW'(acc_r) + TW'(1)) << shift_amt;
      root_ge   = (TW'(x_r) >= t_val);
      y_inc     = y_r + WIDTH'(root_ge);
      last_iter = (i_r == IW'(K - 1));
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_r <= S_IDLE;
      else        state_r <= state_nxt;
   end

   always_comb begin
      state_nxt = state_r;
      case (state_r)
         S_IDLE:      if (start_i) state_nxt = (mode_i == 2'd2) ? S_MUL : S_ROOT_PREP;
         S_ROOT_PREP: state_nxt = S_ROOT_MUL;
         S_ROOT_MUL:  if (cnt_r == '0) state_nxt = S_ROOT_CMP;
         S_ROOT_CMP: begin
            if (!last_iter)            state_nxt = S_ROOT_PREP;
            else if (mode_r == 2'd1)   state_nxt = S_DONE;
            else                       state_nxt = S_MUL;
         end
         S_MUL:       if (cnt_r == '0) state_nxt = S_DONE;
         S_DONE:      state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         a_r      <= '0;
         x_r      <= '0;
         y_r      <= '0;
         mode_r   <= '0;
         i_r      <= '0;
         cnt_r    <= '0;
         mcand_r  <= '0;
         acc_r    <= '0;
         mplier_r <= '0;
         y_bo     <= '0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state_r)
            S_IDLE: if (start_i) begin
               a_r      <= a_i;
               x_r      <= b_i;
               mode_r   <= (mode_i == 2'd3) ? 2'd0 : mode_i;
               y_r      <= '0;
               i_r      <= '0;
               busy_o   <= 1'b1;
               acc_r    <= '0;
               mcand_r  <= MW'(a_i);
               mplier_r <= {1'b0, b_i};
               cnt_r    <= CW'(WIDTH - 1);
            end
            S_ROOT_PREP: begin
               y_r      <= {y_r[WIDTH-2:0], 1'b0};
               mcand_r  <= MW'({y_r, 1'b0});
               mplier_r <= {y_r, 1'b0} + (WIDTH+1)'(1);
               acc_r    <= '0;
               cnt_r    <= CW'(WIDTH);
            end
            S_ROOT_MUL, S_MUL: begin
               if (mplier_r[0]) acc_r <= acc_r + mcand_r;
               mcand_r  <= mcand_r << 1;
               mplier_r <= mplier_r >> 1;
               cnt_r    <= cnt_r - CW'(1);
            end
            S_ROOT_CMP: begin
               if (root_ge) x_r <= x_r - t_val[WIDTH-1:0];
               y_r <= y_inc;
               if (!last_iter) i_r <= i_r + IW'(1);
               // preload the final product; ROOT_PREP overwrites it if more iterations follow
               mcand_r  <= MW'(a_r);
               mplier_r <= {1'b0, y_inc};
               acc_r    <= '0;
               cnt_r    <= CW'(WIDTH - 1);
            end
            S_DONE: begin
               y_bo   <= (mode_r == 2'd1) ? {{WIDTH{1'b0}}, y_r} : acc_r[2*WIDTH-1:0];
               done_o <= 1'b1;
               busy_o <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ab_cbrt_mul_param.sv
// Directed bench for ab_cbrt_mul_param: 8-bit instance for all modes, 16-bit instance for width regression.
`timescale 1ns/1ps
module tb_ab_cbrt_mul_param;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic [7:0]  a8 = '0, b8 = '0;
   logic [1:0]  mode8 = '0;
   logic        start8 = 1'b0;
   logic [15:0] y8;
   logic        busy8, done8;

   logic [15:0] a16 = '0, b16 = '0;
   logic [1:0]  mode16 = '0;
   logic        start16 = 1'b0;
   logic [31:0] y16;
   logic        busy16, done16;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ab_cbrt_mul_param #(.WIDTH(8)) dut8 (
      .clk_i(clk), .rst_i(rst_n), .a_i(a8), .b_i(b8), .mode_i(mode8),
      .start_i(start8), .y_bo(y8), .busy_o(busy8), .done_o(done8)
   );

   ab_cbrt_mul_param #(.WIDTH(16)) dut16 (
      .clk_i(clk), .rst_i(rst_n), .a_i(a16), .b_i(b16), .mode_i(mode16),
      .start_i(start16), .y_bo(y16), .busy_o(busy16), .done_o(done16)
   );

   // Launches one 8-bit op, scrambles the inputs after the accept edge, returns result and latency (-1 on timeout).
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                         output logic [15:0] y, output int lat,
                         output logic bsy_acc, output logic bsy_done);
      @(negedge clk);
      a8 = a; b8 = b; mode8 = m; start8 = 1'b1;
      @(posedge clk); #1;
      bsy_acc = busy8;
      start8 = 1'b0; a8 = ~a; b8 = ~b; mode8 = 2'd1;
      lat = -1; y = '0; bsy_done = 1'b1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk); #1;
         if (done8) begin
            lat = n; y = y8; bsy_done = busy8;
            break;
         end
      end
   endtask

   task automatic run_op16(input logic [15:0] a, input logic [15:0] b,
                           output logic [31:0] y, output int lat);
      @(negedge clk);
      a16 = a; b16 = b; mode16 = 2'd0; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0; a16 = ~a; b16 = ~b;
      lat = -1; y = '0;
      for (int n = 1; n <= 300; n++) begin
         @(posedge clk); #1;
         if (done16) begin
            lat = n; y = y16;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #2;
      checks++; if (y8 !== 16'd0)   begin errors++; $display("FAIL reset_y8 got %0d want 0", y8); end
      checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8 got %b want 0", busy8); end
      checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done8 got %b want 0", done8); end
      checks++; if (y16 !== 32'd0)  begin errors++; $display("FAIL reset_y16 got %0d want 0", y16); end
      #20 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL idle_busy8 got %b want 0", busy8); end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  av [3] = '{8'd1, 8'd2, 8'd3};
      logic [7:0]  bv [3] = '{8'd64, 8'd27, 8'd8};
      logic [15:0] ev [3] = '{16'd4, 16'd6, 16'd6};
      logic [15:0] y;
      int lat;
      logic ba, bd;
      for (int k = 0; k < 3; k++) begin
         run_op(av[k], bv[k], 2'd0, y, lat, ba, bd);
         checks++; if (y !== ev[k]) begin errors++; $display("FAIL b2b_y[%0d] got %0d want %0d", k, y, ev[k]); end
         checks++; if (lat != 42)   begin errors++; $display("FAIL b2b_lat[%0d] got %0d want 42", k, lat); end
         checks++; if (ba !== 1'b1) begin errors++; $display("FAIL b2b_busy_accept[%0d] got %b want 1", k, ba); end
         checks++; if (bd !== 1'b0) begin errors++; $display("FAIL b2b_busy_done[%0d] got %b want 0", k, bd); end
         @(posedge clk); #1;
         checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL b2b_done_width[%0d] got %b want 0", k, done8); end
         checks++; if (y8 !== ev[k])   begin errors++; $display("FAIL b2b_hold[%0d] got %0d want %0d", k, y8, ev[k]); end
      end
   endtask

   task automatic test_modes();
      logic [7:0]  av [4] = '{8'd255, 8'd255, 8'd7,   8'd2};
      logic [7:0]  bv [4] = '{8'd255, 8'd255, 8'd125, 8'd64};
      logic [1:0]  mv [4] = '{2'd0,   2'd2,   2'd1,   2'd3};
      logic [15:0] ev [4] = '{16'd1530, 16'd65025, 16'd5, 16'd8};
      int          lv [4] = '{42, 9, 34, 42};
      logic [15:0] y;
      int lat;
      logic ba, bd;
      for (int k = 0; k < 4; k++) begin
         run_op(av[k], bv[k], mv[k], y, lat, ba, bd);
         checks++; if (y !== ev[k]) begin errors++; $display("FAIL mode%0d_y got %0d want %0d", mv[k], y, ev[k]); end
         checks++; if (lat != lv[k]) begin errors++; $display("FAIL mode%0d_lat got %0d want %0d", mv[k], lat, lv[k]); end
      end
   endtask

   task automatic test_boundaries();
      logic [7:0]  av [5] = '{8'd5,  8'd0,  8'd0,   8'd9, 8'd9};
      logic [7:0]  bv [5] = '{8'd0,  8'd64, 8'd200, 8'd7, 8'd8};
      logic [1:0]  mv [5] = '{2'd0,  2'd0,  2'd2,   2'd1, 2'd1};
      logic [15:0] ev [5] = '{16'd0, 16'd0, 16'd0,  16'd1, 16'd2};
      logic [15:0] y;
      int lat;
      logic ba, bd;
      for (int k = 0; k < 5; k++) begin
         run_op(av[k], bv[k], mv[k], y, lat, ba, bd);
         checks++; if (y !== ev[k]) begin errors++; $display("FAIL edge[%0d]_y got %0d want %0d", k, y, ev[k]); end
         checks++; if (lat < 0)     begin errors++; $display("FAIL edge[%0d]_timeout got %0d want done", k, lat); end
      end
   endtask

   task automatic test_busy_ignore();
      int dones = 0;
      logic [15:0] yv = '0;
      @(negedge clk);
      a8 = 8'd1; b8 = 8'd64; mode8 = 2'd0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk); #1;
         if (n == 5)  begin a8 = 8'd9; b8 = 8'd9; start8 = 1'b1; end
         if (n == 20) start8 = 1'b0;
         if (done8) begin dones++; yv = y8; end
      end
      checks++; if (dones != 1)     begin errors++; $display("FAIL busy_ignore_dones got %0d want 1", dones); end
      checks++; if (yv !== 16'd4)   begin errors++; $display("FAIL busy_ignore_y got %0d want 4", yv); end
      checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL busy_ignore_idle got %b want 0", busy8); end
   endtask

   task automatic test_async_reset();
      int dones = 0;
      logic [15:0] y;
      int lat;
      logic ba, bd;
      @(negedge clk);
      a8 = 8'd3; b8 = 8'd8; mode8 = 2'd0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (20) @(posedge clk);
      #3 rst_n = 1'b0;
      #0.5;
      checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", busy8); end
      checks++; if (y8 !== 16'd0)   begin errors++; $display("FAIL areset_y got %0d want 0", y8); end
      checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL areset_done got %b want 0", done8); end
      #0.5 rst_n = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(posedge clk); #1;
         if (done8) dones++;
      end
      checks++; if (dones != 0)   begin errors++; $display("FAIL areset_no_done got %0d want 0", dones); end
      checks++; if (y8 !== 16'd0) begin errors++; $display("FAIL areset_y_after got %0d want 0", y8); end
      run_op(8'd3, 8'd8, 2'd0, y, lat, ba, bd);
      checks++; if (y !== 16'd6) begin errors++; $display("FAIL areset_restart_y got %0d want 6", y); end
      checks++; if (lat != 42)   begin errors++; $display("FAIL areset_restart_lat got %0d want 42", lat); end
   endtask

   task automatic test_width16();
      logic [15:0] av [3] = '{16'd1000,  16'd65535,   16'd1000};
      logic [15:0] bv [3] = '{16'd46656, 16'd65535,   16'd46655};
      logic [31:0] ev [3] = '{32'd36000, 32'd2621400, 32'd35000};
      logic [31:0] y;
      int lat;
      for (int k = 0; k < 3; k++) begin
         run_op16(av[k], bv[k], y, lat);
         checks++; if (y !== ev[k]) begin errors++; $display("FAIL w16_y[%0d] got %0d want %0d", k, y, ev[k]); end
         checks++; if (lat != 131)  begin errors++; $display("FAIL w16_lat[%0d] got %0d want 131", k, lat); end
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_modes();
      test_boundaries();
      test_busy_ignore();
      test_async_reset();
      test_width16();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
